// File: rtl/cntr_bs_frfcfs.sv
// Per-bank FR-FCFS scheduler: shared request buffer, age cap against starvation,
// and a read/write bus mode with write-count watermark hysteresis.
module cntr_bs_frfcfs #(
    parameter logic READ    = 1'b0,
    parameter logic WRITE   = 1'b1,
    parameter int   RA      = 16,
    parameter int   CA      = 10,
    parameter int   DQ      = 16,
    parameter int   IDX     = 7,
    parameter int   DEPTH   = 8,
    parameter int   AGE_W   = 4,
    parameter int   AGE_MAX = 12,
    parameter int   WR_HI   = 6,
    parameter int   WR_LO   = 2,
    localparam int  SW      = $clog2(DEPTH),
    localparam int  CW      = $clog2(DEPTH+1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           valid_i,
    input  logic           t_i,
    input  logic [RA-1:0]  ra_i,
    input  logic [CA-1:0]  ca_i,
    input  logic [DQ-1:0]  dq_i,
    input  logic [IDX-1:0] idx_i,
    output logic           grant,
    input  logic           ready,
    output logic           valid_o,
    output logic           t_o,
    output logic [RA-1:0]  ra_o,
    output logic [CA-1:0]  ca_o,
    output logic [DQ-1:0]  dq_o,
    output logic [IDX-1:0] idx_o,
    output logic           mode_o,
    output logic           rd_empty,
    output logic [CW-1:0]  num
);
    typedef struct packed {
        logic           t;
        logic [RA-1:0]  ra;
        logic [CA-1:0]  ca;
        logic [DQ-1:0]  dq;
        logic [IDX-1:0] idx;
    } req_t;

    typedef enum logic {M_RD = 1'b0, M_WR = 1'b1} mode_e;

    req_t                        ent_q [DEPTH];
    req_t                        ent_d [DEPTH];
    logic [DEPTH-1:0]            vld_q, vld_d;
    logic [DEPTH-1:0][AGE_W-1:0] age_q, age_d;

    req_t           out_q, out_d;
    logic           ovld_q, ovld_d;
    logic [RA-1:0]  open_ra_q, open_ra_d;
    logic           open_v_q, open_v_d;
    logic [CW-1:0]  num_q, num_d;
    logic [CW-1:0]  rd_cnt_q, rd_cnt_d;
    logic           rd_empty_q, rd_empty_d;
    mode_e          mode_q, mode_d;

    req_t             req_in;
    logic             fr_any;
    logic [SW-1:0]    fr_slot;
    logic [DEPTH-1:0] urg, hit, typ, pick;
    logic             cand;
    logic [SW-1:0]    sel;
    logic [AGE_W-1:0] best;
    req_t             sel_req;
    logic             load;
    logic             push_w, push_r, pop_w, pop_r;

    assign req_in = '{t: t_i, ra: ra_i, ca: ca_i, dq: dq_i, idx: idx_i};
    assign mode_o = (mode_q == M_WR) ? WRITE : READ;

    // Lowest free slot; grant only looks at registered occupancy.
    always_comb begin
        fr_any  = 1'b0;
        fr_slot = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!vld_q[i]) begin
                fr_any  = 1'b1;
                fr_slot = SW'(i);
            end
        end
    end

    assign grant = valid_i & fr_any;

    // Candidate classes, first non-empty class wins; inside it oldest, then lowest slot.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            urg[i] = vld_q[i] && (age_q[i] >= AGE_W'(AGE_MAX));
            typ[i] = vld_q[i] && (ent_q[i].t == mode_o);
            hit[i] = typ[i] && open_v_q && (ent_q[i].ra == open_ra_q);
        end
        if (|urg)      pick = urg;
        else if (|hit) pick = hit;
        else           pick = typ;
    end

    always_comb begin
        cand = 1'b0;
        sel  = '0;
        best = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (pick[i] && (!cand || age_q[i] > best)) begin
                cand = 1'b1;
                sel  = SW'(i);
                best = age_q[i];
            end
        end
    end

    assign sel_req = ent_q[sel];
    assign load    = cand & (~ovld_q | ready);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            vld_d[i] = vld_q[i];
            age_d[i] = age_q[i];
            if (grant && fr_slot == SW'(i)) begin
                ent_d[i] = req_in;
                vld_d[i] = 1'b1;
                age_d[i] = '0;
            end else if (load && sel == SW'(i)) begin
                vld_d[i] = 1'b0;
                age_d[i] = '0;
            end else if (load && vld_q[i] && age_q[i] != '1) begin
                age_d[i] = age_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        out_d     = out_q;
        ovld_d    = ovld_q;
        open_ra_d = open_ra_q;
        open_v_d  = open_v_q;
        if (load) begin
            out_d     = sel_req;
            ovld_d    = 1'b1;
            open_ra_d = sel_req.ra;
            open_v_d  = 1'b1;
        end else if (ready) begin
            ovld_d    = 1'b0;
        end
    end

    assign push_w = grant & (t_i == WRITE);
    assign push_r = grant & (t_i == READ);
    assign pop_w  = load & (sel_req.t == WRITE);
    assign pop_r  = load & (sel_req.t == READ);

    always_comb begin
        num_d      = num_q + CW'(push_w) - CW'(pop_w);
        rd_cnt_d   = rd_cnt_q + CW'(push_r) - CW'(pop_r);
        rd_empty_d = (rd_cnt_d == '0);
    end

    // Mode decision runs on registered counts, so it lags the buffer by one edge.
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            M_RD: if (num_q >= CW'(WR_HI) || (rd_empty_q && num_q != '0)) mode_d = M_WR;
            M_WR: if (num_q == '0 || (num_q <= CW'(WR_LO) && !rd_empty_q)) mode_d = M_RD;
            default: mode_d = M_RD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            vld_q      <= '0;
            age_q      <= '0;
            out_q      <= '0;
            ovld_q     <= 1'b0;
            open_ra_q  <= '0;
            open_v_q   <= 1'b0;
            num_q      <= '0;
            rd_cnt_q   <= '0;
            rd_empty_q <= 1'b1;
            mode_q     <= M_RD;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            vld_q      <= vld_d;
            age_q      <= age_d;
            out_q      <= out_d;
            ovld_q     <= ovld_d;
            open_ra_q  <= open_ra_d;
            open_v_q   <= open_v_d;
            num_q      <= num_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_empty_q <= rd_empty_d;
            mode_q     <= mode_d;
        end
    end

    assign valid_o  = ovld_q;
    assign t_o      = out_q.t;
    assign ra_o     = out_q.ra;
    assign ca_o     = out_q.ca;
    assign dq_o     = out_q.dq;
    assign idx_o    = out_q.idx;
    assign rd_empty = rd_empty_q;
    assign num      = num_q;
endmodule
